// File: rtl/decade_counter_pkg.sv
// Shared constants and next-state helper for BCD digit counters.
// next_count wraps in both directions and recovers illegal states to 0.
package decade_counter_pkg;

  localparam int unsigned DEC_MODULUS = 10;
  localparam int unsigned DEC_WIDTH   = 4;

  function automatic int unsigned next_count(
    input int unsigned count,
    input logic        up,
    input int unsigned modulus
  );
    if (count >= modulus) return 0;
    if (up) return (count == modulus - 1) ? 0 : count + 1;
    return (count == 0) ? modulus - 1 : count - 1;
  endfunction

endpackage

// File: rtl/decade_counter_if.sv
// Control/status bundle of one counter digit.
// master: drives en/up/clear/load/load_value; slave: drives count/tc.
interface decade_counter_if
  import decade_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_WIDTH
);

  logic             en;
  logic             up;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, up, clear, load, load_value,
    input  count, tc
  );

  modport slave (
    input  en, up, clear, load, load_value,
    output count, tc
  );

endinterface

// File: rtl/decade_counter.sv
// Modulo-MODULUS up/down counter: clear > load > en > hold.
// Ports: clock, reset_n (async, active low), cnt (slave bundle).
module decade_counter
  import decade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEC_MODULUS,
  parameter int unsigned WIDTH   = DEC_WIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  decade_counter_if.slave   cnt
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == WIDTH'(MODULUS - 1));
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    priority case (1'b1)
      cnt.clear: count_d = '0;
      // out-of-range load values are never stored
      cnt.load: count_d = (32'(cnt.load_value) >= MODULUS)
                          ? '0 : cnt.load_value;
      cnt.en: count_d = WIDTH'(next_count(32'(count_q),
                                          cnt.up, MODULUS));
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign cnt.count = count_q;
  // illegal states match neither compare, so tc stays low there
  assign cnt.tc    = cnt.en & ((cnt.up & at_max) |
                               (~cnt.up & at_zero));

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter plus a two-digit cascade.
// No ports.
module tb_decade_counter;
  import decade_counter_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       t;
  } exp_t;

  logic clock;
  logic reset_n;
  logic rst2_n;
  int   n_vec;
  int   n_miss;
  exp_t sb[$];

  decade_counter_if #(.WIDTH(4)) u_if ();
  decade_counter_if #(.WIDTH(4)) lsd_if ();
  decade_counter_if #(.WIDTH(4)) msd_if ();

  decade_counter #(.MODULUS(10), .WIDTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cnt     (u_if)
  );

  decade_counter #(.MODULUS(10), .WIDTH(4)) u_lsd (
    .clock   (clock),
    .reset_n (rst2_n),
    .cnt     (lsd_if)
  );

  decade_counter #(.MODULUS(10), .WIDTH(4)) u_msd (
    .clock   (clock),
    .reset_n (rst2_n),
    .cnt     (msd_if)
  );

  assign msd_if.en = lsd_if.tc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input logic t);
    exp_t e;
    e.tag = tag;
    e.c   = 4'(c);
    e.t   = t;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk(e.tag, int'(u_if.count), int'(e.c));
    chk({e.tag, "_tc"}, int'(u_if.tc), int'(e.t));
  endtask

  task automatic drive(input logic en, input logic up,
                       input logic clr, input logic ld,
                       input int lv);
    u_if.en         = en;
    u_if.up         = up;
    u_if.clear      = clr;
    u_if.load       = ld;
    u_if.load_value = 4'(lv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    n_vec  = 0;
    n_miss = 0;
    reset_n = 1'b0;
    rst2_n  = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    lsd_if.en = 1'b1;
    lsd_if.up = 1'b1;
    lsd_if.clear = 1'b0;
    lsd_if.load = 1'b0;
    lsd_if.load_value = '0;
    msd_if.up = 1'b1;
    msd_if.clear = 1'b0;
    msd_if.load = 1'b0;
    msd_if.load_value = '0;

    // power-up hold
    #1;
    chk("rst_cnt", int'(u_if.count), 0);
    #14;
    reset_n = 1'b1;
    #2;
    chk("hold17", int'(u_if.count), 0);
    #3;
    chk("hold20", int'(u_if.count), 0);
    chk("hold20_tc", int'(u_if.tc), 0);
    u_if.en = 1'b1;

    for (int i = 1; i <= 11; i++) begin
      e = i % 10;
      push($sformatf("up%0d", i), e, e == 9);
      sample();
    end

    // down count after reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    chk("dn_rst", int'(u_if.count), 0);
    chk("dn_rst_tc", int'(u_if.tc), 1);
    for (int i = 1; i <= 11; i++) begin
      e = (10 - (i % 10)) % 10;
      push($sformatf("dn%0d", i), e, e == 0);
      sample();
    end

    // load / clear priority
    drive(1'b0, 1'b1, 1'b0, 1'b1, 7);
    push("ld7", 7, 1'b0);
    sample();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12);
    push("ld12", 0, 1'b0);
    sample();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5);
    push("clr_ld", 0, 1'b0);
    sample();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3);
    push("ld3", 3, 1'b0);
    sample();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    push("ld9_en", 9, 1'b1);
    sample();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
    push("clr_en", 0, 1'b0);
    sample();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    push("wrap_dn", 9, 1'b0);
    sample();

    // async reset mid-count
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5);
    push("ld5", 5, 1'b0);
    sample();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
    push("to6", 6, 1'b0);
    sample();
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst", int'(u_if.count), 0);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("resume%0d", i), i, 1'b0);
      sample();
    end

    // load pending while reset held over an edge is lost
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_ld", int'(u_if.count), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    #2;
    reset_n = 1'b1;

    // helper function, including illegal-state recovery
    chk("nc_12up", int'(next_count(12, 1'b1, 10)), 0);
    chk("nc_15dn", int'(next_count(15, 1'b0, 10)), 0);
    chk("nc_9up", int'(next_count(9, 1'b1, 10)), 0);
    chk("nc_0dn", int'(next_count(0, 1'b0, 10)), 9);
    chk("nc_4up", int'(next_count(4, 1'b1, 10)), 5);
    chk("nc_m16", int'(next_count(15, 1'b1, 16)), 0);

    // two-digit cascade
    @(negedge clock);
    rst2_n = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("lsd%0d", i), int'(lsd_if.count), i % 10);
      chk($sformatf("msd%0d", i), int'(msd_if.count),
          (i / 10) % 10);
    end
    chk("casc_msd", int'(msd_if.count), 2);
    chk("casc_lsd", int'(lsd_if.count), 3);

    if (sb.size() != 0) chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
